// File: rtl/button_event_unit_if.sv
// Signal bundle between the debouncer/traffic FSM side and button_event_unit.
// The master drives the debounced levels and the walk ack; the slave returns the events.
interface button_event_unit_if #(
    parameter int CNT_W = 8
);
    logic             reset_db_in;
    logic             walkRequest_db_in;
    logic             reprogram_db_in;
    logic             walk_clear_in;
    logic             soft_reset_out;
    logic             walk_pending_out;
    logic             reprogram_pulse_out;
    logic [CNT_W-1:0] walk_count_out;

    modport master (
        output reset_db_in, walkRequest_db_in, reprogram_db_in, walk_clear_in,
        input  soft_reset_out, walk_pending_out, reprogram_pulse_out, walk_count_out
    );

    modport slave (
        input  reset_db_in, walkRequest_db_in, reprogram_db_in, walk_clear_in,
        output soft_reset_out, walk_pending_out, reprogram_pulse_out, walk_count_out
    );
endinterface

// File: rtl/button_event_unit.sv
// Turns debounced button levels into registered events: sticky walk request,
// stretched soft reset and a rate-limited reprogram pulse.
//
// state      | meaning
// S_IDLE     | waiting for a reset button rising edge
// S_STRETCH  | soft reset asserted, counting down the stretch
// S_WAIT_REL | stretch done, waiting for the reset button to be released
module button_event_unit #(
    parameter int RESET_STRETCH = 16,
    parameter int HOLDOFF       = 64,
    parameter int CNT_W         = 8
) (
    input  logic                 clk,
    input  logic                 sys_reset,
    button_event_unit_if.slave   bus
);
    localparam int RS_W = (RESET_STRETCH > 1) ? $clog2(RESET_STRETCH) : 1;
    localparam int HO_W = $clog2(HOLDOFF + 1);
    localparam logic [RS_W-1:0]  STRETCH_LOAD = RS_W'(RESET_STRETCH - 1);
    localparam logic [HO_W-1:0]  HOLDOFF_LOAD = HO_W'(HOLDOFF);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_STRETCH, S_WAIT_REL} rst_state_e;

    rst_state_e       state_q;
    logic [RS_W-1:0]  stretch_cnt_q;
    logic             soft_reset_q;

    logic             reset_prev_q, walk_prev_q, rep_prev_q;
    logic             walk_pending_q, walk_pending_d;
    logic [CNT_W-1:0] walk_count_q, walk_count_d;
    logic             rep_pulse_q, rep_pulse_d;
    logic [HO_W-1:0]  holdoff_q, holdoff_d;

    logic reset_rise, walk_rise, rep_rise, in_stretch, walk_acc, rep_acc;

    assign reset_rise = bus.reset_db_in       & ~reset_prev_q;
    assign walk_rise  = bus.walkRequest_db_in & ~walk_prev_q;
    assign rep_rise   = bus.reprogram_db_in   & ~rep_prev_q;
    assign in_stretch = (state_q == S_STRETCH);
    assign walk_acc   = walk_rise & ~in_stretch;
    assign rep_acc    = rep_rise & ~in_stretch & (holdoff_q == '0);

    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q       <= S_IDLE;
            stretch_cnt_q <= '0;
            soft_reset_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (reset_rise) begin
                        state_q       <= S_STRETCH;
                        stretch_cnt_q <= STRETCH_LOAD;
                        soft_reset_q  <= 1'b1;
                    end
                end
                S_STRETCH: begin
                    if (stretch_cnt_q == '0) begin
                        state_q      <= S_WAIT_REL;
                        soft_reset_q <= 1'b0;
                    end else begin
                        stretch_cnt_q <= stretch_cnt_q - RS_W'(1);
                    end
                end
                S_WAIT_REL: begin
                    // A held button gives one stretch only; re-arm after release.
                    if (!bus.reset_db_in) state_q <= S_IDLE;
                end
                default: begin
                    state_q      <= S_IDLE;
                    soft_reset_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        walk_pending_d = walk_pending_q;
        walk_count_d   = walk_count_q;
        rep_pulse_d    = 1'b0;
        holdoff_d      = holdoff_q;
        if (in_stretch) begin
            walk_pending_d = 1'b0;
            walk_count_d   = '0;
            holdoff_d      = '0;
        end else begin
            // A new request wins over a simultaneous clear so it is never lost.
            if (walk_acc)               walk_pending_d = 1'b1;
            else if (bus.walk_clear_in) walk_pending_d = 1'b0;
            if (walk_acc && walk_count_q != CNT_MAX)
                walk_count_d = walk_count_q + CNT_W'(1);
            if (rep_acc) begin
                rep_pulse_d = 1'b1;
                holdoff_d   = HOLDOFF_LOAD;
            end else if (holdoff_q != '0) begin
                holdoff_d = holdoff_q - HO_W'(1);
            end
        end
    end

    // Previous samples reset high so a level already asserted at release is not an edge.
    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            reset_prev_q   <= 1'b1;
            walk_prev_q    <= 1'b1;
            rep_prev_q     <= 1'b1;
            walk_pending_q <= 1'b0;
            walk_count_q   <= '0;
            rep_pulse_q    <= 1'b0;
            holdoff_q      <= '0;
        end else begin
            reset_prev_q   <= bus.reset_db_in;
            walk_prev_q    <= bus.walkRequest_db_in;
            rep_prev_q     <= bus.reprogram_db_in;
            walk_pending_q <= walk_pending_d;
            walk_count_q   <= walk_count_d;
            rep_pulse_q    <= rep_pulse_d;
            holdoff_q      <= holdoff_d;
        end
    end

    assign bus.soft_reset_out      = soft_reset_q;
    assign bus.walk_pending_out    = walk_pending_q;
    assign bus.reprogram_pulse_out = rep_pulse_q;
    assign bus.walk_count_out      = walk_count_q;
endmodule

// File: tb/tb_button_event_unit.sv
// Directed bench for button_event_unit: default-parameter instance plus a
// 2-bit-counter instance for saturation and asynchronous reset.
module tb_button_event_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    button_event_unit_if #(.CNT_W(8)) bus_a ();
    button_event_unit_if #(.CNT_W(2)) bus_b ();

    button_event_unit #(.RESET_STRETCH(16), .HOLDOFF(64), .CNT_W(8)) dut_a (
        .clk       (clk),
        .sys_reset (rst),
        .bus       (bus_a)
    );

    button_event_unit #(.RESET_STRETCH(4), .HOLDOFF(8), .CNT_W(2)) dut_b (
        .clk       (clk),
        .sys_reset (rst),
        .bus       (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int hi_cnt;
        int pcount;
        int waited;
        int exp_b [6];
        checks = 0;
        errors = 0;
        exp_b  = '{1, 2, 3, 3, 3, 3};

        rst = 1'b1;
        bus_a.reset_db_in = 1'b0; bus_a.walkRequest_db_in = 1'b1;
        bus_a.reprogram_db_in = 1'b0; bus_a.walk_clear_in = 1'b0;
        bus_b.reset_db_in = 1'b0; bus_b.walkRequest_db_in = 1'b0;
        bus_b.reprogram_db_in = 1'b0; bus_b.walk_clear_in = 1'b0;
        #12;
        chk("rst_soft", int'(bus_a.soft_reset_out), 0);
        chk("rst_pending", int'(bus_a.walk_pending_out), 0);
        chk("rst_count", int'(bus_a.walk_count_out), 0);
        chk("rst_pulse", int'(bus_a.reprogram_pulse_out), 0);
        rst = 1'b0;

        // walk held high through reset release: no event
        repeat (3) tick();
        chk("held_walk_pending", int'(bus_a.walk_pending_out), 0);
        chk("held_walk_count", int'(bus_a.walk_count_out), 0);
        bus_a.walkRequest_db_in = 1'b0; tick();
        bus_a.walkRequest_db_in = 1'b1; tick();
        chk("walk1_pending", int'(bus_a.walk_pending_out), 1);
        chk("walk1_count", int'(bus_a.walk_count_out), 1);
        bus_a.walkRequest_db_in = 1'b0; tick();

        // edge together with clear keeps the request
        bus_a.walkRequest_db_in = 1'b1; bus_a.walk_clear_in = 1'b1; tick();
        chk("edge_clear_pending", int'(bus_a.walk_pending_out), 1);
        chk("edge_clear_count", int'(bus_a.walk_count_out), 2);
        bus_a.walkRequest_db_in = 1'b0; tick();
        chk("clear_pending", int'(bus_a.walk_pending_out), 0);
        chk("clear_count", int'(bus_a.walk_count_out), 2);
        bus_a.walk_clear_in = 1'b0;

        // reset press held 100 cycles
        bus_a.reset_db_in = 1'b1;
        hi_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == 0) chk("stretch_start", int'(bus_a.soft_reset_out), 1);
            if (bus_a.soft_reset_out) hi_cnt++;
        end
        chk("stretch_len_held", hi_cnt, 16);
        chk("stretch_clears_count", int'(bus_a.walk_count_out), 0);
        bus_a.reset_db_in = 1'b0; tick();
        chk("no_retrigger", int'(bus_a.soft_reset_out), 0);
        bus_a.reset_db_in = 1'b1;
        hi_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus_a.soft_reset_out) hi_cnt++;
        end
        chk("stretch_len_repress", hi_cnt, 16);
        bus_a.reset_db_in = 1'b0; tick(); tick();

        // walk pending with count 5, then reset press
        for (int i = 0; i < 5; i++) begin
            bus_a.walkRequest_db_in = 1'b1; tick();
            bus_a.walkRequest_db_in = 1'b0; tick();
        end
        chk("five_pending", int'(bus_a.walk_pending_out), 1);
        chk("five_count", int'(bus_a.walk_count_out), 5);
        bus_a.reset_db_in = 1'b1; tick();
        bus_a.walkRequest_db_in = 1'b1; tick();
        chk("stretch_pending_zero", int'(bus_a.walk_pending_out), 0);
        chk("stretch_count_zero", int'(bus_a.walk_count_out), 0);
        bus_a.walkRequest_db_in = 1'b0; tick();
        bus_a.walkRequest_db_in = 1'b1; tick();
        chk("stretch_walk_ignored_p", int'(bus_a.walk_pending_out), 0);
        chk("stretch_walk_ignored_c", int'(bus_a.walk_count_out), 0);
        bus_a.walkRequest_db_in = 1'b0;
        waited = 0;
        while (bus_a.soft_reset_out && waited < 40) begin
            tick();
            waited++;
        end
        chk("stretch_end_timeout", int'(waited < 40), 1);
        bus_a.reset_db_in = 1'b0; tick(); tick();
        bus_a.walkRequest_db_in = 1'b1; tick();
        chk("post_stretch_walk", int'(bus_a.walk_count_out), 1);
        bus_a.walkRequest_db_in = 1'b0; tick();

        // reprogram holdoff: edges at 0, 10, 64 -> only t=0 pulses
        bus_a.reprogram_db_in = 1'b1; tick();
        chk("rep_t0", int'(bus_a.reprogram_pulse_out), 1);
        pcount = 0;
        for (int t = 1; t < 70; t++) begin
            bus_a.reprogram_db_in = (t == 10 || t == 64);
            tick();
            if (bus_a.reprogram_pulse_out) pcount++;
        end
        chk("rep_dropped", pcount, 0);

        // edge exactly when holdoff has reached 0 is accepted
        bus_a.reprogram_db_in = 1'b1; tick();
        chk("rep2_t0", int'(bus_a.reprogram_pulse_out), 1);
        pcount = 0;
        for (int t = 1; t <= 65; t++) begin
            bus_a.reprogram_db_in = (t == 65);
            tick();
            if (bus_a.reprogram_pulse_out) pcount++;
        end
        chk("rep2_t65", int'(bus_a.reprogram_pulse_out), 1);
        chk("rep2_count", pcount, 1);
        bus_a.reprogram_db_in = 1'b0; tick();
        chk("rep2_width", int'(bus_a.reprogram_pulse_out), 0);

        // saturation on the 2-bit instance while dut_a stretches
        bus_a.reset_db_in = 1'b1; tick();
        for (int i = 0; i < 6; i++) begin
            bus_b.walkRequest_db_in = 1'b1; tick();
            chk($sformatf("sat_count_%0d", i), int'(bus_b.walk_count_out), exp_b[i]);
            bus_b.walkRequest_db_in = 1'b0; tick();
        end
        chk("a_soft_before_async", int'(bus_a.soft_reset_out), 1);
        chk("b_pending_before_async", int'(bus_b.walk_pending_out), 1);

        // asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        chk("async_a_soft", int'(bus_a.soft_reset_out), 0);
        chk("async_b_count", int'(bus_b.walk_count_out), 0);
        chk("async_b_pending", int'(bus_b.walk_pending_out), 0);
        chk("async_a_pulse", int'(bus_a.reprogram_pulse_out), 0);
        #10;
        rst = 1'b0;
        bus_a.reset_db_in = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
